seven_seg_mux_n: RTL and testbench
==================================

# seven_seg_mux_n

Parametrised N-digit multiplexed 7-segment display driver. It is the next generation of the team's 4-digit scanner and adds:
- configurable digit count;
- tear-free double-buffered loading;
- per-digit decimal points and leading-zero blanking;
- anti-ghosting dead time and PWM brightness.

It sits between the arithmetic/BCD datapath and the board's common-anode display pins.

## Interface
- `NUM_DIGITS`, 4: digits driven, 2..8.
- `DISPLAY_REFRESH`, 27000: clock cycles per digit slot, ≥ `BLANK_CYCLES`+2.
- `BLANK_CYCLES`, 270: dead-time cycles at the start of each slot, all anodes off.
- `BRIGHT_W`, 4: brightness control width.
- `clk`  in  1  system clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `load_i`  in  1  one-cycle strobe; samples `value_i`/`dp_i`.
- `value_i`  in  4*NUM_DIGITS  digit k = `value_i[4k+3:4k]`; digit 0 is rightmost.
- `dp_i`  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- `lzb_i`  in  1  leading-zero blanking enable.
- `bright_i`  in  BRIGHT_W  duty level; 0 = dark, all-ones = full on.
- `anodo_o`  out  NUM_DIGITS  active-low digit enables.
- `catodo_o`  out  7  active-low segments; bit 6..0 = g..a.
- `dp_o`  out  1  active-low decimal point.
- `digit_idx_o`  out  $clog2(NUM_DIGITS)  index of the current slot.
- `frame_o`  out  1  one-cycle pulse when the index wraps to 0.

## Operation
- Reset, held while `rst_i`=1:
  - `anodo_o` all 1, `catodo_o`=7'b1111111, `dp_o`=1, `digit_idx_o`=0, `frame_o`=0;
  - slot counter=`DISPLAY_REFRESH`-1, PWM phase=0;
  - pending and active buffers = 0, pending_valid=0.
- Slot counter: counts down to 0, then reloads `DISPLAY_REFRESH`-1.
- Digit index: increments on reload, modulo `NUM_DIGITS`; wraps NUM_DIGITS-1→0, correct for non-power-of-two counts.
- Slot position: p = `DISPLAY_REFRESH`-1-count.
- Digit k is lit only when all of these hold: index=k, p ≥ `BLANK_CYCLES`, and PWM on.
  - PWM phase is a free-running `BRIGHT_W`-bit counter.
  - PWM on when phase < `bright_i`, or when `bright_i` is all-ones.
- When not lit: the whole `anodo_o` bus is 1 and `catodo_o`/`dp_o` are all 1. No stale segments are driven.
- Double buffer:
  - `load_i` writes `value_i`/`dp_i` to pending and sets pending_valid.
  - On the frame boundary (count=0 and index=NUM_DIGITS-1), pending is copied to active and pending_valid is cleared.
  - `load_i` asserted on the boundary cycle bypasses pending and is committed at that same boundary.
  - Multiple loads within one frame: the last one wins.
- Decode, from the active buffer:
  - values 0–9 use the standard glyphs (0=1000000 … 9=0010000);
  - values 10–15 depend on the macro (see Configuration).
- Leading-zero blanking (`lzb_i`=1): digit k>0 shows segments off when it and every higher digit are 0. Its dp still follows `dp_i`. Digit 0 is never blanked.
- `reset` mid-frame: all state returns to the reset values on the next edge. Active contents are lost.

## Timing
- All outputs are registered. Outputs reflect slot state with exactly one cycle of latency.
- `frame_o` is high on the first cycle of digit 0's slot; the first frame after reset does not pulse.
- Load to visible change: at most one frame (NUM_DIGITS×DISPLAY_REFRESH cycles) plus 1.
- Lit window per slot: `DISPLAY_REFRESH`-`BLANK_CYCLES` cycles, gated by PWM.
- `bright_i` and `lzb_i` are sampled every cycle; no buffering.

## Configuration
- `SEVSEG_HEX_EN` defined: values 10–15 render as A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- `SEVSEG_HEX_EN` undefined: values 10–15 render as blank (1111111).
- Leading-zero blanking treats only value 0 as zero in both builds.

## Structure
- Package `seven_seg_pkg`:
  - segment glyph constants for 0–F and SEG_BLANK;
  - bit positions a..g;
  - the `NUM_DIGITS` legality check.
- Sub-module `seg_glyph_decoder`: combinational, 4-bit value in, 7-bit active-low glyph out. It holds the `SEVSEG_HEX_EN` option.

## Test plan
All scenarios use NUM_DIGITS=3, DISPLAY_REFRESH=8, BLANK_CYCLES=2, BRIGHT_W=2 unless stated.
- Reset and scan, `bright_i`=3:
  - outputs hold reset values during reset;
  - `anodo_o` sequences 110, 101, 011, with 2 dark cycles per slot;
  - `frame_o` pulses every 24 cycles.
- Load value 0x123 mid-frame: the old value is shown until the boundary; 1, 2, 3 appear from the next frame. Load 0x456 exactly on the boundary cycle: 4, 5, 6 appear in that frame.
- `lzb_i`=1 with value 0x005, dp_i=3'b010:
  - digit 2 blank;
  - digit 1 segments blank with `dp_o`=0;
  - digit 0 shows 0010010.
- Value 0x0AF: `SEVSEG_HEX_EN` build shows F=0001110 and A=0001000; non-hex build shows 1111111 on both digits.
- Brightness:
  - `bright_i`=1: the lit-slot anode is low 1 cycle in 4;
  - `bright_i`=0: `anodo_o` is never low;
  - `bright_i`=3: low for all 6 lit cycles.
- `rst_i` mid-slot with NUM_DIGITS=5: outputs return to reset values in 1 cycle; after release the index wraps 4→0 correctly.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed 7-segment driver: segment bit positions,
// active-low glyphs for 0-F, digit-count legality check and the glyph lookup.
package seven_seg_pkg;

  // Segment bit positions inside the 7-bit cathode bus (bit 6..0 = g..a).
  localparam int unsigned SEG_A_BIT = 0;
  localparam int unsigned SEG_B_BIT = 1;
  localparam int unsigned SEG_C_BIT = 2;
  localparam int unsigned SEG_D_BIT = 3;
  localparam int unsigned SEG_E_BIT = 4;
  localparam int unsigned SEG_F_BIT = 5;
  localparam int unsigned SEG_G_BIT = 6;
  localparam int unsigned SEG_W     = SEG_G_BIT + 1;

  // Active-low glyphs, gfedcba.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam int unsigned MIN_DIGITS = 2;
  localparam int unsigned MAX_DIGITS = 8;

  // Legal digit counts for the scanner.
  function automatic bit num_digits_ok(input int unsigned n);
    return (n >= MIN_DIGITS) && (n <= MAX_DIGITS);
  endfunction

  // Nibble to glyph; 10-15 show letters only when hex_en is set.
  function automatic logic [SEG_W-1:0] glyph_of(input logic [3:0] v, input bit hex_en);
    logic [SEG_W-1:0] g;
    g = SEG_BLANK;
    case (v)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = hex_en ? SEG_HEX_A : SEG_BLANK;
      4'hB: g = hex_en ? SEG_HEX_B : SEG_BLANK;
      4'hC: g = hex_en ? SEG_HEX_C : SEG_BLANK;
      4'hD: g = hex_en ? SEG_HEX_D : SEG_BLANK;
      4'hE: g = hex_en ? SEG_HEX_E : SEG_BLANK;
      4'hF: g = hex_en ? SEG_HEX_F : SEG_BLANK;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational nibble-to-glyph decoder. Define SEVSEG_HEX_EN to render 10-15
// as A b C d E F; otherwise those values render blank.
module seg_glyph_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0]       value,
  output logic [SEG_W-1:0] glyph_c
);

`ifdef SEVSEG_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  // Table lookup of the active-low glyph.
  always_comb begin
    glyph_c = glyph_of(value, HEX_EN);
  end

endmodule

// File: rtl/seven_seg_mux_n.sv
// N-digit multiplexed common-anode 7-segment driver with double-buffered
// loading, per-digit decimal points, leading-zero blanking, dead time and PWM.
// Build option: SEVSEG_HEX_EN (in seg_glyph_decoder) enables hex glyphs.
module seven_seg_mux_n
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned DISPLAY_REFRESH = 27000,
  parameter int unsigned BLANK_CYCLES    = 270,
  parameter int unsigned BRIGHT_W        = 4
) (
  input  logic                          clk,
  input  logic                          rst_i,
  input  logic                          load_i,
  input  logic [4*NUM_DIGITS-1:0]       value_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  input  logic                          lzb_i,
  input  logic [BRIGHT_W-1:0]           bright_i,
  output logic [NUM_DIGITS-1:0]         anodo_o,
  output logic [SEG_W-1:0]              catodo_o,
  output logic                          dp_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic                          frame_o
);

  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W   = $clog2(DISPLAY_REFRESH);
  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
  localparam int unsigned LIT_MAX = DISPLAY_REFRESH - 1 - BLANK_CYCLES;

  if (!num_digits_ok(NUM_DIGITS)) begin : g_bad_num_digits
    $error("seven_seg_mux_n: NUM_DIGITS must be in 2..8");
  end
  if (DISPLAY_REFRESH < BLANK_CYCLES + 2) begin : g_bad_refresh
    $error("seven_seg_mux_n: DISPLAY_REFRESH must be >= BLANK_CYCLES+2");
  end

  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [BRIGHT_W-1:0]   phase_q;
  logic                  wrap_q;
  logic [VAL_W-1:0]      pend_val_q;
  logic [NUM_DIGITS-1:0] pend_dp_q;
  logic                  pend_valid_q;
  logic [VAL_W-1:0]      act_val_q;
  logic [NUM_DIGITS-1:0] act_dp_q;

  logic                  slot_end_c;
  logic                  frame_end_c;
  logic                  lit_c;
  logic [NUM_DIGITS-1:0] anode_c;
  logic [NUM_DIGITS-1:0] blank_c;
  logic                  hi_zero_c;
  logic [3:0]            cur_val_c;
  logic                  cur_dp_c;
  logic                  cur_blank_c;
  logic [SEG_W-1:0]      glyph_c;

  // Slot/frame boundaries, lit window and the one-cold anode pattern.
  always_comb begin
    slot_end_c  = (cnt_q == '0);
    frame_end_c = slot_end_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
    lit_c       = (cnt_q <= CNT_W'(LIT_MAX)) &&
                  ((bright_i == '1) || (phase_q < bright_i));
    anode_c     = ~(NUM_DIGITS'(1) << idx_q);
  end

  // Leading-zero mask: a digit blanks when it and every higher digit are zero.
  always_comb begin
    hi_zero_c = 1'b1;
    blank_c   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      hi_zero_c  = hi_zero_c && (act_val_q[4*k +: 4] == 4'h0);
      blank_c[k] = lzb_i && hi_zero_c && (k != 0);
    end
  end

  // Select the active-buffer nibble, dp and blank flag for the current slot.
  always_comb begin
    cur_val_c   = 4'h0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_val_c   = act_val_q[4*k +: 4];
        cur_dp_c    = act_dp_q[k];
        cur_blank_c = blank_c[k];
      end
    end
  end

  seg_glyph_decoder u_dec (
    .value   (cur_val_c),
    .glyph_c (glyph_c)
  );

  // Slot down-counter, digit index (modulo NUM_DIGITS) and free-running PWM phase.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q   <= CNT_W'(DISPLAY_REFRESH - 1);
      idx_q   <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      phase_q <= phase_q + BRIGHT_W'(1);
      wrap_q  <= frame_end_c;
      if (slot_end_c) begin
        cnt_q <= CNT_W'(DISPLAY_REFRESH - 1);
        idx_q <= frame_end_c ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Double buffer: loads park in pending; commit at the frame boundary, where a
  // same-cycle load bypasses pending.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
    end else if (frame_end_c) begin
      if (load_i) begin
        act_val_q <= value_i;
        act_dp_q  <= dp_i;
      end else if (pend_valid_q) begin
        act_val_q <= pend_val_q;
        act_dp_q  <= pend_dp_q;
      end
      pend_valid_q <= 1'b0;
    end else if (load_i) begin
      pend_val_q   <= value_i;
      pend_dp_q    <= dp_i;
      pend_valid_q <= 1'b1;
    end
  end

  // Registered pin drive; everything is dark outside the lit window.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      anodo_o     <= '1;
      catodo_o    <= SEG_BLANK;
      dp_o        <= 1'b1;
      digit_idx_o <= '0;
      frame_o     <= 1'b0;
    end else begin
      anodo_o     <= lit_c ? anode_c : '1;
      catodo_o    <= (lit_c && !cur_blank_c) ? glyph_c : SEG_BLANK;
      dp_o        <= lit_c ? ~cur_dp_c : 1'b1;
      digit_idx_o <= idx_q;
      frame_o     <= wrap_q;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Directed bench for seven_seg_mux_n: 3-digit instance (refresh 8, blank 2,
// 2-bit brightness) checked every cycle, plus a 5-digit instance for reset
// and non-power-of-two index wrap.
module tb_seven_seg_mux_n;

  logic        clk;
  logic        rst_i;
  logic        load_i;
  logic [11:0] value_i;
  logic [2:0]  dp_i;
  logic        lzb_i;
  logic [1:0]  bright_i;
  logic [2:0]  anodo_o;
  logic [6:0]  catodo_o;
  logic        dp_o;
  logic [1:0]  digit_idx_o;
  logic        frame_o;

  logic        rst5;
  logic        load5;
  logic [19:0] value5;
  logic [4:0]  dpin5;
  logic        lzb5;
  logic [1:0]  bright5;
  logic [4:0]  anodo5;
  logic [6:0]  catodo5;
  logic        dp5;
  logic [2:0]  idx5;
  logic        frame5;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned edges;
  int unsigned edges5;
  int unsigned last_t;
  int unsigned last_t5;
  int unsigned lit_cnt;
  logic [2:0][6:0] cur_g;
  logic [2:0]      cur_dp;

  typedef struct {
    logic [11:0]     value;
    logic [2:0]      dp;
    logic            lzb;
    logic [1:0]      bright;
    logic [2:0][6:0] g;
    int unsigned     lit;
  } vec_t;

  vec_t vecs[9];

  seven_seg_mux_n #(
    .NUM_DIGITS(3), .DISPLAY_REFRESH(8), .BLANK_CYCLES(2), .BRIGHT_W(2)
  ) dut (
    .clk(clk), .rst_i(rst_i), .load_i(load_i), .value_i(value_i), .dp_i(dp_i),
    .lzb_i(lzb_i), .bright_i(bright_i), .anodo_o(anodo_o), .catodo_o(catodo_o),
    .dp_o(dp_o), .digit_idx_o(digit_idx_o), .frame_o(frame_o)
  );

  seven_seg_mux_n #(
    .NUM_DIGITS(5), .DISPLAY_REFRESH(8), .BLANK_CYCLES(2), .BRIGHT_W(2)
  ) dut5 (
    .clk(clk), .rst_i(rst5), .load_i(load5), .value_i(value5), .dp_i(dpin5),
    .lzb_i(lzb5), .bright_i(bright5), .anodo_o(anodo5), .catodo_o(catodo5),
    .dp_o(dp5), .digit_idx_o(idx5), .frame_o(frame5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; output sampled after edge n reflects slot state n-1.
  always @(posedge clk) begin
    edges  <= rst_i ? 0 : edges + 1;
    edges5 <= rst5 ? 0 : edges5 + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string name, input int unsigned t,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, act, exp);
    end
  endtask

  // One cycle of the 3-digit instance against the timing formulas.
  task automatic check_main();
    int unsigned t, p, idx, ph;
    logic pwm, lit, ed, ef;
    logic [2:0] ea;
    logic [6:0] ec;
    @(negedge clk);
    t   = edges - 1;
    last_t = t;
    p   = t % 8;
    idx = (t / 8) % 3;
    ph  = t % 4;
    pwm = (bright_i == 2'd3) || (ph < 32'(bright_i));
    lit = (p >= 2) && pwm;
    ea  = lit ? ~(3'b001 << idx) : 3'b111;
    ec  = lit ? cur_g[idx] : 7'h7f;
    ed  = lit ? ~cur_dp[idx] : 1'b1;
    ef  = (t % 24 == 0) && (t != 0);
    cmp("anodo", t, 32'(anodo_o), 32'(ea));
    cmp("catodo", t, 32'(catodo_o), 32'(ec));
    cmp("dp", t, 32'(dp_o), 32'(ed));
    cmp("idx", t, 32'(digit_idx_o), idx);
    cmp("frame", t, 32'(frame_o), 32'(ef));
    if (anodo_o != 3'b111) lit_cnt++;
  endtask

  // Check cycles until the slot-state index modulo 24 reaches m.
  task automatic run_until(input int unsigned m);
    int n;
    n = 0;
    do begin
      check_main();
      n++;
    end while (((last_t % 24) != m) && (n < 30));
    cmp("run_until", last_t, last_t % 24, m);
  endtask

  // One cycle of the 5-digit instance (active buffer all zero, full brightness).
  task automatic check_u5();
    int unsigned t, p, idx;
    logic lit, ef;
    logic [4:0] ea;
    @(negedge clk);
    t   = edges5 - 1;
    last_t5 = t;
    p   = t % 8;
    idx = (t / 8) % 5;
    lit = (p >= 2);
    ea  = lit ? ~(5'b00001 << idx) : 5'b11111;
    ef  = (t % 40 == 0) && (t != 0);
    cmp("u5_anodo", t, 32'(anodo5), 32'(ea));
    cmp("u5_catodo", t, 32'(catodo5), lit ? 32'h40 : 32'h7f);
    cmp("u5_idx", t, 32'(idx5), idx);
    cmp("u5_frame", t, 32'(frame5), 32'(ef));
  endtask

  task automatic check_reset3(input string tag);
    cmp({tag, "_anodo"}, 0, 32'(anodo_o), 32'h7);
    cmp({tag, "_catodo"}, 0, 32'(catodo_o), 32'h7f);
    cmp({tag, "_dp"}, 0, 32'(dp_o), 32'h1);
    cmp({tag, "_idx"}, 0, 32'(digit_idx_o), 32'h0);
    cmp({tag, "_frame"}, 0, 32'(frame_o), 32'h0);
  endtask

  task automatic check_reset5(input string tag);
    cmp({tag, "_anodo"}, 0, 32'(anodo5), 32'h1f);
    cmp({tag, "_catodo"}, 0, 32'(catodo5), 32'h7f);
    cmp({tag, "_dp"}, 0, 32'(dp5), 32'h1);
    cmp({tag, "_idx"}, 0, 32'(idx5), 32'h0);
    cmp({tag, "_frame"}, 0, 32'(frame5), 32'h0);
  endtask

  initial begin
    vecs[0] = '{value: 12'h123, dp: 3'b000, lzb: 1'b0, bright: 2'd3,
                g: {7'b1111001, 7'b0100100, 7'b0110000}, lit: 18};
    vecs[1] = '{value: 12'h005, dp: 3'b010, lzb: 1'b1, bright: 2'd3,
                g: {7'b1111111, 7'b1111111, 7'b0010010}, lit: 18};
`ifdef SEVSEG_HEX_EN
    vecs[2] = '{value: 12'h0AF, dp: 3'b000, lzb: 1'b0, bright: 2'd3,
                g: {7'b1000000, 7'b0001000, 7'b0001110}, lit: 18};
    vecs[3] = '{value: 12'h0AF, dp: 3'b000, lzb: 1'b1, bright: 2'd2,
                g: {7'b1111111, 7'b0001000, 7'b0001110}, lit: 6};
    vecs[7] = '{value: 12'hEDC, dp: 3'b000, lzb: 1'b0, bright: 2'd3,
                g: {7'b0000110, 7'b0100001, 7'b1000110}, lit: 18};
    vecs[8] = '{value: 12'hB00, dp: 3'b001, lzb: 1'b1, bright: 2'd3,
                g: {7'b0000011, 7'b1000000, 7'b1000000}, lit: 18};
`else
    vecs[2] = '{value: 12'h0AF, dp: 3'b000, lzb: 1'b0, bright: 2'd3,
                g: {7'b1000000, 7'b1111111, 7'b1111111}, lit: 18};
    vecs[3] = '{value: 12'h0AF, dp: 3'b000, lzb: 1'b1, bright: 2'd2,
                g: {7'b1111111, 7'b1111111, 7'b1111111}, lit: 6};
    vecs[7] = '{value: 12'hEDC, dp: 3'b000, lzb: 1'b0, bright: 2'd3,
                g: {7'b1111111, 7'b1111111, 7'b1111111}, lit: 18};
    vecs[8] = '{value: 12'hB00, dp: 3'b001, lzb: 1'b1, bright: 2'd3,
                g: {7'b1111111, 7'b1000000, 7'b1000000}, lit: 18};
`endif
    vecs[4] = '{value: 12'h789, dp: 3'b101, lzb: 1'b0, bright: 2'd1,
                g: {7'b1111000, 7'b0000000, 7'b0010000}, lit: 3};
    vecs[5] = '{value: 12'h406, dp: 3'b111, lzb: 1'b1, bright: 2'd0,
                g: {7'b0011001, 7'b1000000, 7'b0000010}, lit: 0};
    vecs[6] = '{value: 12'h000, dp: 3'b000, lzb: 1'b1, bright: 2'd2,
                g: {7'b1111111, 7'b1111111, 7'b1000000}, lit: 6};

    vectors = 0; miscompares = 0; lit_cnt = 0;
    rst_i = 1'b1; load_i = 1'b0; value_i = '0; dp_i = '0; lzb_i = 1'b0; bright_i = 2'd3;
    rst5 = 1'b1; load5 = 1'b0; value5 = '0; dpin5 = '0; lzb5 = 1'b0; bright5 = 2'd3;
    cur_g  = {7'b1000000, 7'b1000000, 7'b1000000};
    cur_dp = 3'b000;

    repeat (3) @(negedge clk);
    check_reset3("rst");
    check_reset5("rst5");
    rst_i = 1'b0;

    // Plain scan of the reset contents for two frames.
    repeat (48) check_main();

    // Mid-frame loads: old contents until the boundary, new ones for the next frame.
    for (int i = 0; i < 9; i++) begin
      run_until(9);
      load_i = 1'b1; value_i = vecs[i].value; dp_i = vecs[i].dp;
      check_main();
      load_i = 1'b0;
      run_until(23);
      lzb_i = vecs[i].lzb; bright_i = vecs[i].bright;
      cur_g = vecs[i].g; cur_dp = vecs[i].dp;
      lit_cnt = 0;
      repeat (24) check_main();
      cmp("lit_cycles", last_t, lit_cnt, vecs[i].lit);
    end

    // Two loads in one frame: the later one is committed.
    lzb_i = 1'b0; bright_i = 2'd3;
    run_until(4);
    load_i = 1'b1; value_i = 12'h111; dp_i = 3'b111;
    check_main();
    load_i = 1'b0;
    run_until(14);
    load_i = 1'b1; value_i = 12'h222; dp_i = 3'b100;
    check_main();
    load_i = 1'b0;
    run_until(23);
    cur_g = {7'b0100100, 7'b0100100, 7'b0100100}; cur_dp = 3'b100;
    repeat (24) check_main();

    // Load on the boundary cycle lands in the very next frame, then holds.
    run_until(22);
    load_i = 1'b1; value_i = 12'h456; dp_i = 3'b000;
    check_main();
    load_i = 1'b0;
    cur_g = {7'b0011001, 7'b0010010, 7'b0000010}; cur_dp = 3'b000;
    repeat (48) check_main();

    // Five digits: reset mid-slot, then the index must wrap 4 -> 0.
    rst5 = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        check_u5();
        n++;
      end while ((last_t5 != 13) && (n < 40));
      cmp("u5_run", last_t5, last_t5, 13);
    end
    rst5 = 1'b1;
    @(negedge clk);
    check_reset5("rst5_mid");
    rst5 = 1'b0;
    repeat (48) check_u5();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
